// File: rtl/spdif_sample_pairer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spdif_sample_pairer : pairs S/PDIF left/right subframes into a stereo FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module spdif_sample_pairer #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int TIMEOUT_LOG2    = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [23:0]              data_i,
  input  logic                     ack_i,
  input  logic                     lrck_i,
  input  logic                     locked_i,
  input  logic                     clr_i,
  output logic [23:0]              left_o,
  output logic [23:0]              right_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [FIFO_DEPTH_LOG2:0] level_o,
  output logic                     overflow_o,
  output logic [7:0]               err_cnt_o,
  output logic                     stale_o
);

  localparam int                      DEPTH  = 2 ** FIFO_DEPTH_LOG2;
  localparam int                      PW     = FIFO_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]           C_FULL = PW'(DEPTH);
  localparam logic [TIMEOUT_LOG2-1:0] C_WD_MAX = TIMEOUT_LOG2'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [23:0]             pend_q, pend_d;
  logic [PW-1:0]           wr_q, rd_q;
  logic [47:0]             mem_q [DEPTH];
  logic                    ovf_q, ovf_d;
  logic [7:0]              err_q, err_d;
  logic [TIMEOUT_LOG2-1:0] wd_q, wd_d;

  logic          push, seq_err, pop, push_ok, ovf_ev;
  logic [PW-1:0] level;
  logic [47:0]   head;

  assign level   = wr_q - rd_q;
  assign valid_o = (level != '0);
  assign pop     = valid_o && ready_i;
  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign push_ok = push && ((level != C_FULL) || pop);
  assign ovf_ev  = push && !push_ok;
  assign head    = mem_q[rd_q[FIFO_DEPTH_LOG2-1:0]];

  assign left_o     = valid_o ? head[47:24] : 24'd0;
  assign right_o    = valid_o ? head[23:0]  : 24'd0;
  assign level_o    = level;
  assign overflow_o = ovf_q;
  assign err_cnt_o  = err_q;
  assign stale_o    = (wd_q == C_WD_MAX);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    push    = 1'b0;
    seq_err = 1'b0;
    if (!locked_i) begin
      state_d = WAIT_L;
      pend_d  = 24'd0;
    end else if (ack_i) begin
      case (state_q)
        WAIT_L: begin
          if (!lrck_i) begin
            pend_d  = data_i;
            state_d = HAVE_L;
          end else begin
            seq_err = 1'b1;
          end
        end
        HAVE_L: begin
          if (lrck_i) begin
            push    = 1'b1;
            state_d = WAIT_L;
          end else begin
            pend_d  = data_i;
            seq_err = 1'b1;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  // Events coinciding with clr_i take precedence over the clear.
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      err_d = seq_err ? 8'd1 : 8'd0;
      ovf_d = ovf_ev;
    end else begin
      if (seq_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      if (ovf_ev) ovf_d = 1'b1;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (ack_i)                 wd_d = '0;
    else if (wd_q != C_WD_MAX) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_L;
      pend_q  <= 24'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 8'd0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[FIFO_DEPTH_LOG2-1:0]] <= {pend_q, data_i};
  end

endmodule
`default_nettype wire
